// File: rtl/sram_axi_bridge.sv
// Bridges the core's fetch and load/store SRAM-like ports onto one AXI master.
// Reads share a single AR slot tagged by ID; stores use AW/W/B one at a time.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } ar_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    logic    ar_busy, inst_pend, data_pend, aw_busy, w_busy;
    ar_req_t ar_q;
    wr_req_t wr_q;

    logic load_acc, store_acc, fetch_acc;
    logic ar_hs, aw_hs, w_hs;
    logic r_inst, r_data, b_done;

    // Loads take the AR slot ahead of fetches so the core's memory stage is never starved.
    assign load_acc  = ~reset & data_sram_req & ~data_sram_wr & ~data_pend & ~ar_busy;
    assign store_acc = ~reset & data_sram_req & data_sram_wr & ~data_pend & ~aw_busy & ~w_busy;
    assign fetch_acc = ~reset & inst_sram_req & ~inst_pend & ~ar_busy & ~load_acc;

    assign ar_hs = ar_busy & arready;
    assign aw_hs = aw_busy & awready;
    assign w_hs  = w_busy & wready;

    // Responses only count while their port is waiting, so stale beats after a reset vanish.
    assign r_inst = ~reset & rvalid & (rid == ID_INST) & inst_pend;
    assign r_data = ~reset & rvalid & (rid == ID_DATA) & data_pend;
    assign b_done = ~reset & bvalid & data_pend;

    assign inst_sram_addr_ok = fetch_acc;
    assign data_sram_addr_ok = load_acc | store_acc;
    assign inst_sram_data_ok = r_inst;
    assign data_sram_data_ok = r_data | b_done;
    assign inst_sram_rdata   = r_inst ? rdata : 32'd0;
    assign data_sram_rdata   = r_data ? rdata : 32'd0;

    assign arvalid = ar_busy;
    assign arid    = ar_q.id;
    assign araddr  = ar_q.addr;
    assign awvalid = aw_busy;
    assign awaddr  = wr_q.addr;
    assign wvalid  = w_busy;
    assign wdata   = wr_q.data;
    assign wstrb   = wr_q.strb;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_busy   <= 1'b0;
            inst_pend <= 1'b0;
            data_pend <= 1'b0;
            aw_busy   <= 1'b0;
            w_busy    <= 1'b0;
            ar_q      <= '0;
            wr_q      <= '0;
        end else begin
            if (load_acc || fetch_acc) begin
                ar_busy <= 1'b1;
                ar_q.id <= load_acc ? ID_DATA : ID_INST;
                ar_q.addr <= load_acc ? {data_sram_addr[31:2], 2'b00}
                                      : {inst_sram_addr[31:2], 2'b00};
            end else if (ar_hs) begin
                ar_busy <= 1'b0;
            end

            if (fetch_acc)   inst_pend <= 1'b1;
            else if (r_inst) inst_pend <= 1'b0;

            if (load_acc || store_acc)   data_pend <= 1'b1;
            else if (r_data || b_done)   data_pend <= 1'b0;

            if (store_acc) begin
                aw_busy   <= 1'b1;
                w_busy    <= 1'b1;
                wr_q.addr <= {data_sram_addr[31:2], 2'b00};
                wr_q.data <= data_sram_wdata;
                wr_q.strb <= data_sram_wstrb;
            end else begin
                if (aw_hs) aw_busy <= 1'b0;
                if (w_hs)  w_busy  <= 1'b0;
            end
        end
    end

    // Byte offsets are dropped: every AXI beat is a full aligned word.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed cycle table, randomized traffic against a
// transaction-level model, and a reset-mid-transaction sequence.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  arid, rid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] ireq, iaddr, dreq, dwr, daddr, strb, wd, arr, awr, wrdy, rv, rid, rd, bv;
    } in_t;
    typedef struct packed {
        logic [31:0] iaok, daok, idok, ddok, irdata, drdata, arv, arid, araddr, awv, wv;
    } out_t;
    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    task automatic idle_in();
        inst_sram_req = 0; inst_sram_addr = 0; data_sram_req = 0; data_sram_wr = 0;
        data_sram_addr = 0; data_sram_wstrb = 0; data_sram_wdata = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rid = 0; rdata = 0; bvalid = 0;
    endtask

    // Transaction-level model state for the random phase
    bit          i_act, d_act, d_wr, i_out, d_out, ar_slot, aw_pend, w_pend, b_pend;
    logic [31:0] i_a, d_a, d_wd, i_exp_a, d_exp_a, ar_addr, st_addr, st_data;
    logic [3:0]  d_st, ar_id, st_strb;
    logic [3:0]  rq_id[$];
    logic [31:0] rq_addr[$];

    initial begin
        vec_t tbl[$];
        out_t act;
        bit   p_load, p_store, p_fetch, e_idok, e_ddok, gen, done;
        int   idx;

        // ireq iaddr dreq dwr daddr strb wd arr awr wrdy rv rid rd bv | iaok daok idok ddok irdata drdata arv arid araddr awv wv
        tbl.push_back('{'{1,'h1c000001,0,0,0,0,0,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,0,'h1c000000,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,0,'h02800c0c,0}, '{0,0,1,0,'h02800c0c,0,0,0,'h1c000000,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h1c000000,0,0}});
        tbl.push_back('{'{1,'h100,1,0,'h203,0,0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0,'h1c000000,0,0}});
        tbl.push_back('{'{1,'h100,0,0,0,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,1,'h200,0,0}});
        tbl.push_back('{'{1,'h100,0,0,0,0,0,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,1,'h200,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,0,'h100,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,0,'haaaa0000,0}, '{0,0,1,0,'haaaa0000,0,0,0,'h100,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,1,'hbbbb0001,0}, '{0,0,0,1,0,'hbbbb0001,0,0,'h100,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h100,0,0}});
        // store with awready late, wready immediate; a load waits behind it
        tbl.push_back('{'{0,0,1,1,'h80000004,'h3,'h1234,0,0,1,0,0,0,0}, '{0,1,0,0,0,0,0,0,'h100,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,1,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h100,1,1}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h100,1,0}});
        tbl.push_back('{'{0,0,1,0,'h40,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h100,1,0}});
        tbl.push_back('{'{0,0,1,0,'h40,0,0,0,1,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,'h100,1,0}});
        tbl.push_back('{'{0,0,1,0,'h40,0,0,0,0,0,0,0,0,1}, '{0,0,0,1,0,0,0,0,'h100,0,0}});
        tbl.push_back('{'{0,0,1,0,'h40,0,0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0,'h100,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,1,'h40,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,1,'h5555,0}, '{0,0,0,1,0,'h5555,0,1,'h40,0,0}});
        // AR stalled five cycles with both ports requesting
        tbl.push_back('{'{1,'h300,0,0,0,0,0,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,1,'h40,0,0}});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{'{1,'h300,1,0,'h500,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,0,'h300,0,0}});
        tbl.push_back('{'{0,0,1,0,'h500,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,0,'h300,0,0}});
        tbl.push_back('{'{0,0,1,0,'h500,0,0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0,'h300,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,1,1,'h500,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,0,'h11,0}, '{0,0,1,0,'h11,0,0,1,'h500,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,2,'h99,0}, '{0,0,0,0,0,0,0,1,'h500,0,0}});
        tbl.push_back('{'{0,0,0,0,0,0,0,0,0,0,1,1,'h22,0}, '{0,0,0,1,0,'h22,0,1,'h500,0,0}});

        // reset state, with requests and responses present that must be ignored
        reset = 1; idle_in();
        repeat (2) @(posedge clk);
        #1 inst_sram_req = 1; data_sram_req = 1; rvalid = 1; bvalid = 1; arready = 1;
        #4;
        chk("reset_ctrl", 64'({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok,
                                data_sram_data_ok, arvalid, awvalid, wvalid, rready, bready}),
            64'(9'b000000011));
        chk("reset_payload", 64'({arid, araddr, wstrb} | {4'd0, awaddr, 4'd0} | {4'd0, wdata, 4'd0}), 64'd0);
        chk("reset_rdata", 64'({inst_sram_rdata, data_sram_rdata}), 64'd0);
        reset = 0; idle_in();

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            inst_sram_req = tbl[i].i.ireq[0]; inst_sram_addr = tbl[i].i.iaddr;
            data_sram_req = tbl[i].i.dreq[0]; data_sram_wr = tbl[i].i.dwr[0];
            data_sram_addr = tbl[i].i.daddr; data_sram_wstrb = tbl[i].i.strb[3:0];
            data_sram_wdata = tbl[i].i.wd; arready = tbl[i].i.arr[0];
            awready = tbl[i].i.awr[0]; wready = tbl[i].i.wrdy[0];
            rvalid = tbl[i].i.rv[0]; rid = tbl[i].i.rid[3:0]; rdata = tbl[i].i.rd;
            bvalid = tbl[i].i.bv[0];
            #4;
            act = '{32'(inst_sram_addr_ok), 32'(data_sram_addr_ok), 32'(inst_sram_data_ok),
                    32'(data_sram_data_ok), inst_sram_rdata, data_sram_rdata, 32'(arvalid),
                    32'(arid), araddr, 32'(awvalid), 32'(wvalid)};
            checks++;
            if (act !== tbl[i].o) begin
                failures++;
                $display("FAIL table row %0d got=%h exp=%h", i, act, tbl[i].o);
            end
        end
        chk("store_payload", 64'({wstrb, awaddr}), 64'({4'h3, 32'h80000004}));
        chk("store_wdata", 64'(wdata), 64'h1234);

        // randomized traffic against the transaction model
        done = 0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            gen = (cyc < 4000);
            @(posedge clk); #1;
            if (gen && !i_act && $urandom_range(0, 2) == 0) begin i_act = 1; i_a = $urandom; end
            if (gen && !d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_wr = 1'($urandom_range(0, 1)); d_a = $urandom;
                d_wd = $urandom; d_st = 4'($urandom);
            end
            inst_sram_req = i_act; inst_sram_addr = i_a;
            data_sram_req = d_act; data_sram_wr = d_wr; data_sram_addr = d_a;
            data_sram_wdata = d_wd; data_sram_wstrb = d_st;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid = 0; rid = 0; rdata = 0; bvalid = 0;
            if (rq_id.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, rq_id.size() - 1));
                rvalid = 1; rid = rq_id[idx]; rdata = hash(rq_addr[idx]);
                rq_id.delete(idx); rq_addr.delete(idx);
            end else if ($urandom_range(0, 15) == 0) begin
                rvalid = 1; rid = 4'($urandom_range(2, 15)); rdata = $urandom;
            end
            if (b_pend && $urandom_range(0, 1) == 1) begin bvalid = 1; b_pend = 0; end
            #4;
            p_load  = d_act && !d_wr && !d_out && !ar_slot;
            p_store = d_act && d_wr && !d_out && !aw_pend && !w_pend;
            p_fetch = i_act && !i_out && !ar_slot && !p_load;
            chk("rnd_addr_ok", 64'({inst_sram_addr_ok, data_sram_addr_ok}), 64'({p_fetch, p_load || p_store}));
            chk("rnd_valids", 64'({arvalid, awvalid, wvalid}), 64'({ar_slot, aw_pend, w_pend}));
            e_idok = rvalid && rid == 4'd0;
            e_ddok = (rvalid && rid == 4'd1) || bvalid;
            chk("rnd_data_ok", 64'({inst_sram_data_ok, data_sram_data_ok}), 64'({e_idok, e_ddok}));
            if (e_idok) begin chk("rnd_inst_rdata", 64'(inst_sram_rdata), 64'(hash(i_exp_a))); i_out = 0; end
            if (rvalid && rid == 4'd1) chk("rnd_load_rdata", 64'(data_sram_rdata), 64'(hash(d_exp_a)));
            if (e_ddok) d_out = 0;
            if (arvalid && arready) begin
                chk("rnd_ar", 64'({arid, araddr}), 64'({ar_id, ar_addr}));
                rq_id.push_back(arid); rq_addr.push_back(araddr); ar_slot = 0;
            end
            if (awvalid && awready) begin
                chk("rnd_aw", 64'(awaddr), 64'(st_addr)); aw_pend = 0;
                if (!w_pend) b_pend = 1;
            end
            if (wvalid && wready) begin
                chk("rnd_w", 64'({wstrb, wdata}), 64'({st_strb, st_data})); w_pend = 0;
                if (!aw_pend) b_pend = 1;
            end
            if (p_fetch) begin
                i_act = 0; i_out = 1; ar_slot = 1; i_exp_a = {i_a[31:2], 2'b00};
                ar_id = 4'd0; ar_addr = i_exp_a;
            end
            if (p_load) begin
                d_act = 0; d_out = 1; ar_slot = 1; d_exp_a = {d_a[31:2], 2'b00};
                ar_id = 4'd1; ar_addr = d_exp_a;
            end
            if (p_store) begin
                d_act = 0; d_out = 1; aw_pend = 1; w_pend = 1;
                st_addr = {d_a[31:2], 2'b00}; st_data = d_wd; st_strb = d_st;
            end
            done = !gen && !i_act && !d_act && !i_out && !d_out && !b_pend && !ar_slot &&
                   !aw_pend && !w_pend && rq_id.size() == 0;
        end
        chk("rnd_drained", 64'(done), 64'd1);

        // reset with a load sitting in the AR slot; its late response must be dropped
        @(posedge clk); #1 idle_in(); data_sram_req = 1; data_sram_addr = 32'h700;
        #4 chk("rst_mid_accept", 64'(data_sram_addr_ok), 64'd1);
        @(posedge clk); #1 idle_in(); reset = 1;
        @(posedge clk); #1 reset = 0; rvalid = 1; rid = 4'd1; rdata = 32'hdeadbeef;
        #4;
        chk("rst_mid_valids", 64'({arvalid, awvalid, wvalid, data_sram_data_ok, inst_sram_data_ok}), 64'd0);
        chk("rst_mid_araddr", 64'({arid, araddr, data_sram_rdata}), 64'd0);
        @(posedge clk); #1 idle_in(); data_sram_req = 1; data_sram_addr = 32'h704;
        #4 chk("rst_mid_new_load", 64'(data_sram_addr_ok), 64'd1);
        @(posedge clk); #1 idle_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like request/addr_ok/data_ok ports (instruction fetch, read-only; data load/store) into one AXI master port, downstream of the pipeline core. It arbitrates reads onto one AR channel, tags them by ID, steers R responses back, and serialises stores onto AW/W/B. Constant AXI fields (len=0, burst=INCR, size=4 bytes, lock/cache/prot=0, wlast=1, awid=wid=1) are tied off in the top-level wrapper and are not ports.

## Interface
- Parameters: none.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_sram_req  in  1  fetch request
- inst_sram_addr  in  32  fetch byte address
- inst_sram_addr_ok  out  1  fetch request accepted this cycle
- inst_sram_data_ok  out  1  fetch data valid this cycle
- inst_sram_rdata  out  32  fetch data
- data_sram_req  in  1  load/store request
- data_sram_wr  in  1  1 = store
- data_sram_wstrb  in  4  store byte enables
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data
- data_sram_addr_ok  out  1  request accepted this cycle
- data_sram_data_ok  out  1  load data valid / store complete
- data_sram_rdata  out  32  load data
- arid  out  4  0 = fetch, 1 = load
- araddr  out  32  word-aligned read address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  response ID
- rdata  in  32  read data
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  word-aligned write address
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bvalid  in  1  B valid
- bready  out  1  B ready

## Operation
- State: ar_busy (AR register holds request), inst_pend, data_pend (each port max one outstanding), aw_busy, w_busy.
- Load accept: data_sram_addr_ok = data_req & ~wr & ~data_pend & ~ar_busy. Fetch accept: inst_sram_addr_ok = inst_req & ~inst_pend & ~ar_busy & ~(load accepted this cycle). Loads win arbitration.
- On read accept: ar_busy=1, arid/araddr latched ({addr[31:2],2'b00}), pend flag set. arvalid=ar_busy; ar_busy clears on arvalid&arready.
- Store accept: data_sram_addr_ok = data_req & wr & ~data_pend & ~aw_busy & ~w_busy. Sets aw_busy, w_busy, data_pend; latches awaddr (aligned), wdata, wstrb. awvalid=aw_busy, wvalid=w_busy; each clears on its own handshake, any order.
- rready=1, bready=1 permanently after reset. rvalid&rid==0: inst_sram_data_ok=1, inst_sram_rdata=rdata, inst_pend clears. rid==1: data_sram_data_ok=1, data_sram_rdata=rdata, data_pend clears. Other rid ignored.
- bvalid: data_sram_data_ok=1, data_pend clears. One data transaction at a time, so R(id1) and B never collide and no RAW hazard exists.
- Pend flags clear at end of data_ok cycle; a new request on that port is accepted the following cycle, never the same cycle.

## Timing
- Reset: arvalid, awvalid, wvalid, addr_ok, data_ok = 0; araddr, awaddr, wdata, wstrb, arid, rdata outputs = 0; all state flags 0; rready = bready = 1. Reset mid-transaction drops all state; in-flight AXI responses afterwards are ignored.
- addr_ok and data_ok are combinational, single-cycle pulses. Read: accept T, arvalid T+1, earliest data_ok T+2 (arready T+1, rvalid T+2). Store: accept T, awvalid/wvalid T+1, earliest data_ok T+2.
- arvalid/awvalid/wvalid and their payload hold stable until handshake.

## Test plan
- Fetch 0x1c000001, arready=1, rvalid rid=0 rdata=0x02800c0c at T+2 -> araddr=0x1c000000 arid=0 at T+1; inst_sram_data_ok=1 rdata=0x02800c0c at T+2.
- Fetch and load requested same cycle -> data_sram_addr_ok=1, inst_sram_addr_ok=0; fetch accepted after AR handshake; out-of-order R (id0 before id1) each routed to correct port.
- Store addr 0x8000_0004 wstrb=0x3 wdata=0x1234; awready delayed 3 cycles, wready immediate -> wvalid drops T+2, awvalid holds until T+4; data_ok only on bvalid.
- Load requested while store pending -> data_sram_addr_ok=0 until cycle after B response.
- Held arready=0 for 5 cycles -> arvalid, araddr stable; no further addr_ok on either read port.
- Reset asserted with ar_busy and data_pend set -> next cycle all valids 0, late rvalid rid=1 produces no data_ok.
